// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// programmable wait states, byte-enabled stores, and a pass/fail completion mailbox.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request; memory access happens on the accept edge
// ST_WAIT | counting down wait states before the response
// ST_RESP | rsp_valid high for this single cycle, then back to idle
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1,
    parameter int PASS_ADDR   = 100,
    parameter int PASS_DATA   = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        done,
    output logic        pass
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_cnt_next;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          accept;
    logic          legal;
    logic          mailbox_hit;
    logic [AW-1:0] word_idx;

    assign accept   = (state == ST_IDLE) && req_valid;
    assign legal    = (req_addr[1:0] == 2'b00)
                   && ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));
    assign word_idx = req_addr[AW+1:2];

    assign mailbox_hit = accept && legal && req_we
                      && (req_addr == 32'(PASS_ADDR)) && (req_be == 4'hF);

    // Ready is also gated by reset so the core never sees a handshake mid-reset.
    assign req_ready = (state == ST_IDLE) && reset;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;
    assign rsp_err   = (state == ST_RESP) && err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                // Terminal count: the decrement that lands on zero also leaves WAIT.
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= !legal;
            rdata_q <= (legal && !req_we) ? mem[word_idx] : 32'd0;
            if (legal && req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_be[b]) begin
                        mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // First full-word mailbox store decides the verdict; later ones only touch memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (mailbox_hit && !done) begin
            done <= 1'b1;
            pass <= (req_wdata == 32'(PASS_DATA));
        end
    end

endmodule
